// File: rtl/cv32e40p_fpu_wb_tracker.sv
// Issue-side tracker for the fixed-latency FPU: a shift register of in-flight ops
// that schedules writebacks, rejects slot/WAW collisions and flags RAW hazards.
module cv32e40p_fpu_wb_tracker #(
  parameter int FPU_ADDMUL_LAT = 2,
  parameter int FPU_OTHERS_LAT = 2,
  parameter int ZFINX          = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid_i,
  output logic            issue_ready_o,
  input  logic            issue_addmul_i,
  input  logic            issue_we_i,
  input  logic [5:0]      issue_waddr_i,
  input  logic [2:0][5:0] rs_addr_i,
  input  logic [2:0]      rs_en_i,
  output logic            hazard_o,
  output logic            wb_valid_o,
  output logic [5:0]      wb_waddr_o,
  output logic [2:0]      outstanding_o
);

  localparam int D = ((FPU_ADDMUL_LAT > FPU_OTHERS_LAT) ? FPU_ADDMUL_LAT : FPU_OTHERS_LAT) + 1;

  logic [D-1:0] vld_q, vld_d;
  logic [D-1:0] we_q, we_d;
  logic [5:0]   addr_q [D];
  logic [5:0]   addr_d [D];

  logic [2:0] lat;
  logic [5:0] waddr_n;
  logic       slot_busy;
  logic       waw;
  logic       hazard;
  logic [2:0] cnt;
  logic       accept;

  // With Zfinx all operands live in the integer file, so the FP-file bit is dropped
  function automatic logic [5:0] norm_addr(input logic [5:0] a);
    return (ZFINX != 0) ? {1'b0, a[4:0]} : a;
  endfunction

  always_comb begin
    lat       = issue_addmul_i ? 3'(FPU_ADDMUL_LAT) : 3'(FPU_OTHERS_LAT);
    waddr_n   = norm_addr(issue_waddr_i);
    slot_busy = 1'b0;
    waw       = 1'b0;
    hazard    = 1'b0;
    cnt       = '0;
    for (int k = 0; k < D; k++) begin
      if (vld_q[k]) cnt = cnt + 3'd1;
      // the entry in s[L+1] lands in s[L] next cycle, colliding with this issue
      if (k == int'(lat) + 1) slot_busy = vld_q[k];
      if (issue_we_i && vld_q[k] && we_q[k] && (addr_q[k] == waddr_n)) waw = 1'b1;
      for (int j = 0; j < 3; j++) begin
        if (rs_en_i[j] && vld_q[k] && we_q[k] && (addr_q[k] == norm_addr(rs_addr_i[j])))
          hazard = 1'b1;
      end
    end
  end

  assign issue_ready_o = !slot_busy && !waw;
  assign accept        = issue_valid_i && issue_ready_o;

  always_comb begin
    for (int k = 0; k < D - 1; k++) begin
      vld_d[k]  = vld_q[k+1];
      we_d[k]   = we_q[k+1];
      addr_d[k] = addr_q[k+1];
    end
    vld_d[D-1]  = 1'b0;
    we_d[D-1]   = 1'b0;
    addr_d[D-1] = '0;
    if (accept) begin
      for (int k = 0; k < D; k++) begin
        if (k == int'(lat)) begin
          vld_d[k]  = 1'b1;
          we_d[k]   = issue_we_i;
          addr_d[k] = waddr_n;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      we_q  <= '0;
      for (int k = 0; k < D; k++) addr_q[k] <= '0;
    end else begin
      vld_q  <= vld_d;
      we_q   <= we_d;
      addr_q <= addr_d;
    end
  end

  assign wb_valid_o    = vld_q[0] && we_q[0];
  assign wb_waddr_o    = addr_q[0];
  assign hazard_o      = hazard;
  assign outstanding_o = cnt;

endmodule
